// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings and default screen/geometry constants
// for the single-player pong game controller.
package pong_pkg;

  // FSM state encodings (3-bit)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_MISS  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // Default screen and geometry
  localparam int unsigned DEF_WIDTH      = 640;
  localparam int unsigned DEF_HEIGHT     = 480;
  localparam int unsigned DEF_TICK_DIV   = 1000000;
  localparam int unsigned DEF_BALL_R     = 10;
  localparam int unsigned DEF_PAD_W      = 90;
  localparam int unsigned DEF_PAD_Y_TOP  = 460;
  localparam int unsigned DEF_PAD_STEP   = 10;
  localparam int unsigned DEF_LIVES      = 3;
  localparam int unsigned DEF_SERVE_WAIT = 60;

  localparam int unsigned PAD_RESET_LEFT = 190;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..DIV-1 counter; tick is high for the one
// cycle after the counter holds DIV-1.
//   CLOCK_50 : clock
//   rst      : synchronous active-high reset
//   tick     : one-cycle pulse every DIV cycles
module tick_divider
  import pong_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic CLOCK_50,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Counter wraps at DIV-1; tick is registered off the wrap condition
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for single-player VGA pong. Owns ball
// position/direction, paddle, score and lives; moves the ball on each
// divided tick and resolves wall bounces, paddle hits and misses.
//   CLOCK_50, rst          : clock, synchronous active-high reset
//   start                  : start game / restart after game over
//   move_left, move_right  : paddle step pulses
//   ball_x, ball_y         : ball centre
//   pad_left, pad_right    : paddle edges
//   score, lives, state    : game status
//   tick                   : ball-motion tick
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned BALL_R     = DEF_BALL_R,
  parameter int unsigned PAD_W      = DEF_PAD_W,
  parameter int unsigned PAD_Y_TOP  = DEF_PAD_Y_TOP,
  parameter int unsigned PAD_STEP   = DEF_PAD_STEP,
  parameter int unsigned LIVES      = DEF_LIVES,
  parameter int unsigned SERVE_WAIT = DEF_SERVE_WAIT
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [9:0] pad_left,
  output logic [9:0] pad_right,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       tick
);

  localparam int unsigned SCW = (SERVE_WAIT > 0) ? $clog2(SERVE_WAIT + 1) : 1;
  localparam logic [9:0]  X_CENTRE  = 10'(WIDTH / 2);
  localparam logic [8:0]  Y_CENTRE  = 9'(HEIGHT / 2);
  localparam logic [10:0] X_LIM     = 11'(WIDTH - 1);
  localparam logic [9:0]  Y_LIM     = 10'(HEIGHT - 1);
  localparam logic [9:0]  PAD_MAX   = 10'(WIDTH - 1 - PAD_W);
  localparam logic [SCW-1:0] SERVE_N = SCW'(SERVE_WAIT);

  logic [2:0]     r_state, w_state_nxt;
  logic [9:0]     r_x, w_x_nxt;
  logic [8:0]     r_y, w_y_nxt;
  logic           r_dx, w_dx_nxt;
  logic           r_dy, w_dy_nxt;
  logic [7:0]     r_score, w_score_nxt;
  logic [1:0]     r_lives, w_lives_nxt;
  logic [SCW-1:0] r_serve, w_serve_nxt;
  logic [9:0]     r_pad, w_pad_nxt, w_pad_move;
  logic [9:0]     r_pad_right;
  logic           w_tick;
  logic [10:0]    w_x_sum;
  logic [9:0]     w_y_sum;
  logic [10:0]    w_pad_sum;
  logic           w_hit;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .tick     (w_tick)
  );

  // One-bit-wider sums so edge compares cannot wrap
  assign w_x_sum   = {1'b0, r_x} + 11'(BALL_R);
  assign w_y_sum   = {1'b0, r_y} + 10'(BALL_R);
  assign w_pad_sum = {1'b0, r_pad} + 11'(PAD_STEP);
  assign w_hit     = r_dy && (w_y_sum == 10'(PAD_Y_TOP)) &&
                     (r_x >= r_pad) && (r_x <= r_pad_right);

  // Paddle step with clamping at both screen edges; both pulses cancel
  always_comb begin
    w_pad_move = r_pad;
    if (move_left && !move_right) begin
      w_pad_move = (r_pad >= 10'(PAD_STEP)) ? r_pad - 10'(PAD_STEP) : '0;
    end else if (move_right && !move_left) begin
      w_pad_move = (w_pad_sum <= {1'b0, PAD_MAX}) ? w_pad_sum[9:0] : PAD_MAX;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    w_serve_nxt = r_serve;
    w_pad_nxt   = w_pad_move;

    case (r_state)
      ST_IDLE: begin
        w_x_nxt = X_CENTRE;
        w_y_nxt = Y_CENTRE;
        if (start) begin
          w_state_nxt = ST_SERVE;
          w_score_nxt = '0;
          w_lives_nxt = 2'(LIVES);
          w_serve_nxt = '0;
        end
      end
      ST_SERVE: begin
        w_x_nxt  = X_CENTRE;
        w_y_nxt  = Y_CENTRE;
        w_dx_nxt = 1'b1;
        w_dy_nxt = 1'b1;
        if (r_serve >= SERVE_N) begin
          w_state_nxt = ST_PLAY;
        end else if (w_tick) begin
          w_serve_nxt = r_serve + SCW'(1);
        end
      end
      ST_PLAY: begin
        if (w_tick) begin
          if (r_dy && (w_y_sum >= Y_LIM)) begin
            // Ball passed the paddle: freeze it and take a life next cycle
            w_state_nxt = ST_MISS;
          end else begin
            if (r_dx) begin
              if (w_x_sum >= X_LIM) begin
                w_dx_nxt = 1'b0;
                w_x_nxt  = r_x - 10'd1;
              end else begin
                w_x_nxt  = r_x + 10'd1;
              end
            end else if (r_x <= 10'(BALL_R)) begin
              w_dx_nxt = 1'b1;
              w_x_nxt  = r_x + 10'd1;
            end else begin
              w_x_nxt  = r_x - 10'd1;
            end

            if (w_hit) begin
              w_dy_nxt    = 1'b0;
              w_y_nxt     = r_y - 9'd1;
              w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            end else if (r_dy) begin
              w_y_nxt = r_y + 9'd1;
            end else if (r_y <= 9'(BALL_R)) begin
              w_dy_nxt = 1'b1;
              w_y_nxt  = r_y + 9'd1;
            end else begin
              w_y_nxt  = r_y - 9'd1;
            end
          end
        end
      end
      ST_MISS: begin
        w_lives_nxt = r_lives - 2'd1;
        w_x_nxt     = X_CENTRE;
        w_y_nxt     = Y_CENTRE;
        w_serve_nxt = '0;
        w_state_nxt = (r_lives <= 2'd1) ? ST_OVER : ST_SERVE;
      end
      ST_OVER: begin
        w_pad_nxt = r_pad;
        if (start) begin
          w_state_nxt = ST_IDLE;
          w_score_nxt = '0;
          w_lives_nxt = 2'(LIVES);
          w_pad_nxt   = 10'(PAD_RESET_LEFT);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_x         <= X_CENTRE;
      r_y         <= Y_CENTRE;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_score     <= '0;
      r_lives     <= 2'(LIVES);
      r_serve     <= '0;
      r_pad       <= 10'(PAD_RESET_LEFT);
      r_pad_right <= 10'(PAD_RESET_LEFT + PAD_W);
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_serve     <= w_serve_nxt;
      r_pad       <= w_pad_nxt;
      r_pad_right <= w_pad_nxt + 10'(PAD_W);
    end
  end

  assign ball_x    = r_x;
  assign ball_y    = r_y;
  assign pad_left  = r_pad;
  assign pad_right = r_pad_right;
  assign score     = r_score;
  assign lives     = r_lives;
  assign state     = r_state;
  assign tick      = w_tick;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the single-player VGA pong screen. It owns the ball position, ball direction, paddle position, score and lives. It advances the ball on a divided frame tick and resolves wall bounces, paddle hits and misses. It sequences the game through idle, serve, play and game-over phases. Its outputs feed the pixel renderer, which paints the ball and paddle, and a score display.

Parameters:
WIDTH, 640, screen width in pixels
HEIGHT, 480, screen height in pixels
TICK_DIV, 1000000, CLOCK_50 cycles per ball-motion tick
BALL_R, 10, ball radius in pixels
PAD_W, 90, paddle width; pad_right = pad_left + PAD_W
PAD_Y_TOP, 460, paddle top row (the paddle spans PAD_Y_TOP..HEIGHT-1)
PAD_STEP, 10, pixels moved per paddle pulse
LIVES, 3, lives at game start (maximum 3, 2-bit counter)
SERVE_WAIT, 60, ticks spent in SERVE before the ball launches

Ports:
CLOCK_50  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: start game / restart after game over
move_left  in  1  one-cycle pulse, already edge-detected upstream
move_right  in  1  one-cycle pulse, already edge-detected upstream
ball_x  out  10  ball centre x
ball_y  out  9  ball centre y
pad_left  out  10  paddle left edge
pad_right  out  10  paddle right edge (pad_left + PAD_W)
score  out  8  paddle hits, saturates at 255
lives  out  2  remaining lives
state  out  3  current FSM state encoding
tick  out  1  one-cycle motion tick, for debug and render sync

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high (rst); the clock is CLOCK_50.
  - Registered values after reset: ball_x=WIDTH/2 (320), ball_y=HEIGHT/2 (240), pad_left=190, score=0, lives=LIVES, state=IDLE, dx=1, dy=1 (1 = increasing coordinate), tick counter=0, tick=0, serve counter=0.
  - When rst is asserted mid-game, all registers take their reset values on that edge. rst has priority over all other inputs.
- Tick generation:
  - The counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly the one cycle after the counter holds TICK_DIV-1.
  - The counter runs in every state.
- FSM:
  - IDLE: ball held at centre. start -> SERVE; score cleared, lives set to LIVES, serve counter cleared.
  - SERVE: ball held at centre, dx=1, dy=1. Serve counter increments on each tick. When the counter reaches SERVE_WAIT -> PLAY.
  - PLAY: all motion rules below apply, evaluated only on tick. All other cycles hold the ball.
  - MISS: lasts exactly one cycle. lives <= lives-1 and the ball is recentred. If lives was 1 -> OVER, otherwise -> SERVE with the serve counter cleared.
  - OVER: ball held and paddle frozen. start -> IDLE, with score=0, lives=LIVES and pad_left=190.
  - start pulses in SERVE, PLAY or MISS are ignored.
- Motion on tick in PLAY (using current register values):
  - X axis:
    - dx=1 and ball_x+BALL_R >= WIDTH-1: dx<=0 and ball_x<=ball_x-1.
    - dx=0 and ball_x <= BALL_R: dx<=1 and ball_x<=ball_x+1.
    - Otherwise ball_x moves by ±1 in the dx direction.
  - Y axis, top wall: same rule as the X axis, using BALL_R.
  - Y axis, paddle:
    - Condition: dy=1, ball_y+BALL_R == PAD_Y_TOP, and pad_left <= ball_x <= pad_right.
    - Result: dy<=0, ball_y<=ball_y-1, score+1 (saturating at 255).
  - Y axis, miss: dy=1 and ball_y+BALL_R >= HEIGHT-1 -> next state MISS; the ball does not move.
  - X and Y updates happen in the same cycle. The paddle test uses the pre-update ball_x.
- Paddle, active in every state except OVER, every cycle:
  - move_left alone: if pad_left >= PAD_STEP, then pad_left -= PAD_STEP; otherwise pad_left = 0.
  - move_right alone: if pad_left + PAD_STEP <= WIDTH-1-PAD_W, then pad_left += PAD_STEP; otherwise pad_left = WIDTH-1-PAD_W (549).
  - Both pulses asserted together: no move.
  - A paddle move in the same cycle as a tick takes effect after that tick's hit test.
- Arithmetic: all compares are unsigned. Sums are formed one bit wider than the operands so they cannot wrap.

Decomposition:
- pong_pkg holds:
  - the state enum {IDLE, SERVE, PLAY, MISS, OVER}, 3-bit;
  - default screen and geometry constants;
  - PAD_RESET_LEFT=190.
- Sub-module tick_divider: parameterised by DIV, with ports CLOCK_50, rst and tick.
- Everything else stays in pong_game_ctrl.

Test Plan (TICK_DIV=4, SERVE_WAIT=2 in sim):
1. Reset: assert rst for 2 cycles -> ball (320,240), pad_left=190, pad_right=280, score=0, lives=3, state=IDLE, tick=0. Repeat rst mid-PLAY -> same values on the next edge.
2. Paddle clamp: 19 move_left pulses -> pad_left=0; a 20th pulse -> pad_left stays 0. Then 55 move_right pulses -> pad_left=549 and stays there; simultaneous left+right -> unchanged.
3. Serve: start in IDLE -> SERVE. After 2 ticks -> PLAY. The next tick gives ball (321,241) and the following tick (322,242); no movement between ticks.
4. Wall bounce: in PLAY with ball_x=629, dx=1 -> on the tick, dx=0 and ball_x=628. With ball_y=10, dy=0 -> dy=1 and ball_y=11.
5. Paddle hit: serve from centre with 25 move_right pulses (pad_left=440) -> at tick 210, ball (530,450) -> dy=0, ball_y=449, score=1.
6. Miss and game over: paddle at 0, serve -> ball reaches y=469 -> MISS for 1 cycle, lives=2, SERVE. Repeat until lives=0 -> OVER, where paddle pulses are ignored. start -> IDLE, score=0, lives=3.
